// File: rtl/latch_wr_sched.sv
// latch_wr_sched: arbitrates NREQ writers onto one transparent latch bank, driving d/e with a
// setup / enable / hold sequence so d never moves while e is high. Define LATCH_SCHED_RR_EN for round-robin.
module latch_wr_sched #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int EN_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [DW-1:0]           d,
  output logic                    e,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] last_id
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ENABLE,
    S_HOLD
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   d_q, d_d;
  logic            e_q, e_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic [IW-1:0]   last_id_q, last_id_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   win_idx;

`ifdef LATCH_SCHED_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // Scan downward from the farthest offset so the nearest set bit at/after ptr wins last.
  always_comb begin
    logic [IW:0] cand;
    cand    = '0;
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) begin
        cand = cand - (IW+1)'(NREQ);
      end
      if (req[cand[IW-1:0]]) begin
        win_idx = cand[IW-1:0];
      end
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[k[IW-1:0]]) begin
        win_idx = IW'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    d_d       = d_q;
    e_d       = e_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    last_id_d = last_id_q;
    cnt_d     = cnt_q;
`ifdef LATCH_SCHED_RR_EN
    ptr_d     = ptr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          d_d       = wdata[int'(win_idx)*DW +: DW];
          last_id_d = win_idx;
          busy_d    = 1'b1;
          state_d   = S_SETUP;
`ifdef LATCH_SCHED_RR_EN
          ptr_d     = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif
        end
      end
      S_SETUP: begin
        e_d     = 1'b1;
        cnt_d   = CW'(EN_CYCLES - 1);
        state_d = S_ENABLE;
      end
      S_ENABLE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          e_d              = 1'b0;
          gnt_d[last_id_q] = 1'b1;
          state_d          = S_HOLD;
        end
      end
      S_HOLD: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Reset drops e immediately, so the latch bank is never left transparent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      d_q       <= '0;
      e_q       <= 1'b0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      last_id_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      e_q       <= e_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      last_id_q <= last_id_d;
      cnt_q     <= cnt_d;
    end
  end

`ifdef LATCH_SCHED_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign d       = d_q;
  assign e       = e_q;
  assign gnt     = gnt_q;
  assign busy    = busy_q;
  assign last_id = last_id_q;

endmodule

// File: tb/tb_latch_wr_sched.sv
// Self-checking bench for latch_wr_sched: vector table, grant-order sequence, async reset,
// and randomized traffic compared against a transaction-timeline reference model.
module tb_latch_wr_sched;

  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int EN   = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [DW-1:0]     d;
  logic              e;
  logic              busy;
  logic [1:0]        last_id;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;

  latch_wr_sched #(.NREQ(NREQ), .DW(DW), .EN_CYCLES(EN)) dut (
    .clk(clk), .rst(rst), .req(req), .wdata(wdata),
    .gnt(gnt), .d(d), .e(e), .busy(busy), .last_id(last_id)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Winner by the stated arbitration rule.
  function automatic int arb(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
`ifdef LATCH_SCHED_RR_EN
      int c = (p + k) % NREQ;
`else
      int c = k;
`endif
      if (r[c]) return c;
    end
    return 0;
  endfunction

  // Reference model: m_off is the number of edges since the IDLE sample edge (-1 = idle).
  int            m_off;
  logic [DW-1:0] m_d;
  int            m_id;
  int            m_ptr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_off <= -1;
      m_d   <= '0;
      m_id  <= 0;
      m_ptr <= 0;
    end else if (m_off < 0) begin
      if (req != '0) begin
        m_d   <= wdata[arb(req, m_ptr)*DW +: DW];
        m_id  <= arb(req, m_ptr);
        m_ptr <= (arb(req, m_ptr) + 1) % NREQ;
        m_off <= 0;
      end
    end else if (m_off == EN + 1) begin
      m_off <= -1;
    end else begin
      m_off <= m_off + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("model_d", d, m_d);
      check("model_e", e, (m_off >= 1 && m_off <= EN) ? 1 : 0);
      check("model_gnt", gnt, (m_off == EN + 1) ? (64'd1 << m_id) : 64'd0);
      check("model_busy", busy, (m_off >= 0) ? 1 : 0);
      check("model_last_id", last_id, m_id);
    end
  end

  // Any change of d must have e low in the sample before and the sample after.
  logic [DW-1:0] prev_d;
  logic          prev_e;
  bit            prev_vld = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_vld <= 0;
    end else begin
      if (prev_vld && d !== prev_d) begin
        check("d_guard_before", prev_e, 0);
        check("d_guard_after", e, 0);
      end
      prev_d   <= d;
      prev_e   <= e;
      prev_vld <= 1;
    end
  end

  typedef struct {
    logic [NREQ-1:0] req;
    logic [DW-1:0]   data;
    int              exp_id;
    logic [DW-1:0]   exp_d;
    bit              mid_change;
  } vec_t;

  vec_t vecs[7];
  int   exp_order[5];

  initial begin
    int cyc, n, last_t, slot;
    logic e_seen;

    vecs[0] = '{4'b0010, 8'hA5, 1, 8'hA5, 1'b0};
    vecs[1] = '{4'b0001, 8'h3C, 0, 8'h3C, 1'b0};
    vecs[2] = '{4'b0100, 8'hC3, 2, 8'hC3, 1'b0};
    vecs[3] = '{4'b1000, 8'h5E, 3, 8'h5E, 1'b1};
    vecs[4] = '{4'b0100, 8'hFF, 2, 8'hFF, 1'b0};
    vecs[5] = '{4'b0010, 8'h00, 1, 8'h00, 1'b1};
    vecs[6] = '{4'b1000, 8'h81, 3, 8'h81, 1'b0};
`ifdef LATCH_SCHED_RR_EN
    exp_order = '{0, 1, 2, 3, 0};
`else
    exp_order = '{0, 0, 0, 0, 0};
`endif

    rst = 0; req = '0; wdata = '0;
    #1 rst = 1;
    #2;
    check("reset_d", d, 0);
    check("reset_e", e, 0);
    check("reset_gnt", gnt, 0);
    check("reset_busy", busy, 0);
    check("reset_last_id", last_id, 0);
    repeat (3) @(negedge clk);
    rst = 0;
    chk_en = 1;

    // Single writes, back to back, with explicit per-cycle expectations.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = DW'($urandom);
      slot = oh2i(vecs[v].req);
      wdata[slot*DW +: DW] = vecs[v].data;
      req = vecs[v].req;
      for (int k = 0; k <= EN + 2; k++) begin
        @(negedge clk);
        check($sformatf("tbl%0d_d_k%0d", v, k), d, vecs[v].exp_d);
        check($sformatf("tbl%0d_e_k%0d", v, k), e, (k >= 1 && k <= EN) ? 1 : 0);
        check($sformatf("tbl%0d_gnt_k%0d", v, k), gnt,
              (k == EN + 1) ? (64'd1 << vecs[v].exp_id) : 64'd0);
        check($sformatf("tbl%0d_busy_k%0d", v, k), busy, (k <= EN + 1) ? 1 : 0);
        check($sformatf("tbl%0d_last_id_k%0d", v, k), last_id, vecs[v].exp_id);
        if (k == 1 && vecs[v].mid_change) begin
          req = '0;
          for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = DW'($urandom);
        end
        if (k == EN + 1) req = '0;
      end
    end

    // All requesters busy; each drops req for one cycle after its own grant.
    for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = DW'($urandom);
    req = '1;
    n = 0; last_t = 0; cyc = 0;
    while (n < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        check($sformatf("order_%0d", n), oh2i(gnt), exp_order[n]);
        if (n > 0) check($sformatf("spacing_%0d", n), cyc - last_t, EN + 3);
        last_t = cyc;
        n++;
        req = req & ~gnt;
      end else begin
        req = '1;
      end
    end
    if (n < 5) check("order_timeout", n, 5);
    req = '0;
    repeat (EN + 4) @(negedge clk);

    // Asynchronous reset while the latch is enabled.
    for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = DW'($urandom);
    req = 4'b0001;
    cyc = 0;
    @(negedge clk);
    while (e !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    e_seen = e;
    check("rst_mid_e_seen", e_seen, 1);
    req = '0;
    #2 rst = 1;
    #1;
    check("rst_mid_d", d, 0);
    check("rst_mid_e", e, 0);
    check("rst_mid_gnt", gnt, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_last_id", last_id, 0);
    @(negedge clk);
    #2 rst = 0;

    // Randomized traffic obeying the request protocol.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) wdata[i*DW +: DW] = DW'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
      end
    end
    req = '0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
